// File: rtl/key_event.sv
// key_event: turns a debounced key level into press/release/tap/long-press/repeat pulses.
// `release` and `repeat` are language keywords, so those ports are named rel and rpt.
module key_event #(
  parameter logic [23:0] T_LONG     = 24'd50_000_000,
  parameter logic [23:0] T_REPEAT   = 24'd10_000_000,
  parameter int          CNT_W      = 24,
  parameter int          RW         = 8,
  parameter logic        ACTIVE_LOW = 1'b1
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          din,
  output logic          press,
  output logic          rel,
  output logic          tap,
  output logic          long_press,
  output logic          rpt,
  output logic          held,
  output logic [RW-1:0] rpt_cnt
);
  typedef enum logic [1:0] {S_IDLE, S_PRESS, S_LONG} state_t;
  localparam logic [CNT_W-1:0] LONG_M1 = CNT_W'(T_LONG - 24'd1);
  localparam logic [CNT_W-1:0] RPT_M1  = CNT_W'(T_REPEAT - 24'd1);
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [RW-1:0]    rc_n;
  logic             press_n, rel_n, tap_n, long_n, rpt_n;
  logic             act;
  assign act  = din ^ ACTIVE_LOW;
  assign held = state != S_IDLE;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      rpt_cnt    <= '0;
      press      <= 1'b0;
      rel        <= 1'b0;
      tap        <= 1'b0;
      long_press <= 1'b0;
      rpt        <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      rpt_cnt    <= rc_n;
      press      <= press_n;
      rel        <= rel_n;
      tap        <= tap_n;
      long_press <= long_n;
      rpt        <= rpt_n;
    end
  // Key-up is tested first in every held state so it beats any threshold.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rc_n    = rpt_cnt;
    press_n = 1'b0;
    rel_n   = 1'b0;
    tap_n   = 1'b0;
    long_n  = 1'b0;
    rpt_n   = 1'b0;
    case (state)
      S_IDLE:
        if (act) begin
          state_n = S_PRESS;
          press_n = 1'b1;
          cnt_n   = '0;
          rc_n    = '0;
        end
      S_PRESS:
        if (!act) begin
          state_n = S_IDLE;
          rel_n   = 1'b1;
          tap_n   = 1'b1;
        end else if (cnt == LONG_M1) begin
          state_n = S_LONG;
          long_n  = 1'b1;
          cnt_n   = '0;
        end else cnt_n = cnt + 1'b1;
      S_LONG:
        if (!act) begin
          state_n = S_IDLE;
          rel_n   = 1'b1;
        end else if (cnt == RPT_M1) begin
          rpt_n = 1'b1;
          cnt_n = '0;
          rc_n  = &rpt_cnt ? rpt_cnt : rpt_cnt + 1'b1;
        end else cnt_n = cnt + 1'b1;
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_key_event.sv
// tb_key_event: scoreboard bench for key_event with T_LONG=8, T_REPEAT=4, run at RW=8 and RW=2.
module tb_key_event;
  localparam int TL = 8;
  localparam int TR = 4;
  logic clk = 1'b0, n_rst = 1'b0, din = 1'b1;
  logic press8, rel8, tap8, long8, rpt8, held8;
  logic press2, rel2, tap2, long2, rpt2, held2;
  logic [7:0] rc8;
  logic [1:0] rc2;
  int tests = 0, fails = 0;
  logic [21:0] sb[$];
  logic [21:0] exp_v, obs;
  bit m_pressed, m_long;
  int m_hold, m_rc8, m_rc2;

  always #5 clk = ~clk;

  key_event #(.T_LONG(24'd8), .T_REPEAT(24'd4), .CNT_W(24), .RW(8), .ACTIVE_LOW(1'b1)) u8 (
    .clk(clk), .n_rst(n_rst), .din(din), .press(press8), .rel(rel8), .tap(tap8),
    .long_press(long8), .rpt(rpt8), .held(held8), .rpt_cnt(rc8));
  key_event #(.T_LONG(24'd8), .T_REPEAT(24'd4), .CNT_W(24), .RW(2), .ACTIVE_LOW(1'b1)) u2 (
    .clk(clk), .n_rst(n_rst), .din(din), .press(press2), .rel(rel2), .tap(tap2),
    .long_press(long2), .rpt(rpt2), .held(held2), .rpt_cnt(rc2));

  assign obs = {press8, rel8, tap8, long8, rpt8, held8, rc8, press2, rel2, tap2, long2, rpt2, held2, rc2};

  // Reference model: counts edges since the press edge and derives events from that hold time.
  task automatic model_step(input logic d);
    logic p, r, t, l, rp;
    {p, r, t, l, rp} = '0;
    if (!n_rst) begin
      m_pressed = 0; m_long = 0; m_hold = 0; m_rc8 = 0; m_rc2 = 0;
    end else if (!m_pressed) begin
      if (!d) begin
        p = 1; m_pressed = 1; m_long = 0; m_hold = 0; m_rc8 = 0; m_rc2 = 0;
      end
    end else if (d) begin
      r = 1; t = !m_long; m_pressed = 0;
    end else begin
      m_hold++;
      if (m_hold == TL) begin
        l = 1; m_long = 1;
      end else if (m_hold > TL && (m_hold - TL) % TR == 0) begin
        rp = 1;
        if (m_rc8 < 255) m_rc8++;
        if (m_rc2 < 3) m_rc2++;
      end
    end
    sb.push_back({p, r, t, l, rp, m_pressed, 8'(m_rc8), p, r, t, l, rp, m_pressed, 2'(m_rc2)});
  endtask

  task automatic tick(input logic d);
    din = d;
    model_step(d);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    n_rst = 0; din = 1;
    model_step(1'b1);
    #1;
    exp_v = sb.pop_front();
    tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL reset_async got %h want %h", obs, exp_v); end
    repeat (2) @(posedge clk);
    #1 n_rst = 1;
    for (int i = 0; i < 10; i++) begin
      tick(1'b1);
      exp_v = sb.pop_front();
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL reset_idle cyc %0d got %h want %h", i, obs, exp_v); end
    end
  endtask

  task automatic test_tap;
    for (int i = 0; i < 8; i++) begin
      tick(i >= 5);
      exp_v = sb.pop_front();
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL tap cyc %0d got %h want %h", i, obs, exp_v); end
    end
  endtask

  task automatic test_release_on_threshold;
    for (int i = 0; i < 11; i++) begin
      tick(i >= 8);
      exp_v = sb.pop_front();
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL thr_release cyc %0d got %h want %h", i, obs, exp_v); end
    end
  endtask

  task automatic test_long_repeat;
    for (int i = 0; i < 24; i++) begin
      tick(i >= 20);
      exp_v = sb.pop_front();
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL long_repeat cyc %0d got %h want %h", i, obs, exp_v); end
    end
    tests++;
    if (rc8 !== 8'd2) begin fails++; $display("FAIL long_repeat_cnt got %0d want 2", rc8); end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 40; i++) begin
      tick(i >= 35 && i < 38);
      exp_v = sb.pop_front();
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL saturate cyc %0d got %h want %h", i, obs, exp_v); end
    end
    tests++;
    if (rc2 !== 2'd0) begin fails++; $display("FAIL saturate_clear got %0d want 0", rc2); end
    tick(1'b1);
    exp_v = sb.pop_front();
    tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL saturate_tail got %h want %h", obs, exp_v); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] pat = 8'b1010_0101;
    for (int i = 0; i < 8; i++) begin
      tick(pat[i]);
      exp_v = sb.pop_front();
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL back_to_back cyc %0d got %h want %h", i, obs, exp_v); end
    end
    tick(1'b1);
    exp_v = sb.pop_front();
    tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL back_to_back_tail got %h want %h", obs, exp_v); end
  endtask

  task automatic test_reset_mid_press;
    for (int i = 0; i < 11; i++) begin
      tick(1'b0);
      exp_v = sb.pop_front();
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL midrst_pre cyc %0d got %h want %h", i, obs, exp_v); end
    end
    n_rst = 0;
    model_step(1'b0);
    #1;
    exp_v = sb.pop_front();
    tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL midrst_async got %h want %h", obs, exp_v); end
    for (int i = 0; i < 2; i++) begin
      tick(1'b0);
      exp_v = sb.pop_front();
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL midrst_held cyc %0d got %h want %h", i, obs, exp_v); end
    end
    n_rst = 1;
    for (int i = 0; i < 12; i++) begin
      tick(i >= 10);
      exp_v = sb.pop_front();
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL midrst_post cyc %0d got %h want %h", i, obs, exp_v); end
    end
  endtask

  initial begin
    test_reset;
    test_tap;
    test_release_on_threshold;
    test_long_repeat;
    test_saturation;
    test_back_to_back;
    test_reset_mid_press;
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL scoreboard_drain got %0d want 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/key_event.md
# key_event

Push-button event classifier placed directly after the debounce stage, on the consuming end of the debounced key level. It turns a clean key level into single-cycle event pulses: press, release, short tap, long press and auto-repeat. It also provides a held flag and a saturating repeat count. User logic such as counters, mode selects and menus consumes these pulses without doing its own edge detection or timing.

## Interface
- T_LONG, 24'd50_000_000 — cycles the key must stay active after `press` before `long_press` fires; must be ≥ 2.
- T_REPEAT, 24'd10_000_000 — cycles between `long_press` and the first `repeat`, and between successive `repeat` pulses; must be ≥ 1.
- CNT_W, 24 — width of the internal hold counter; must hold max(T_LONG, T_REPEAT) − 1.
- RW, 8 — width of `rpt_cnt`.
- ACTIVE_LOW, 1'b1 — key polarity. 1: `din`=0 means pressed. 0: `din`=1 means pressed.
- clk  input  1  system clock.
- n_rst  input  1  asynchronous, active-low reset.
- din  input  1  debounced key level, already synchronous to `clk`; no extra synchroniser is included.
- press  output  1  one-cycle pulse on the key-down transition.
- release  output  1  one-cycle pulse on every key-up transition.
- tap  output  1  one-cycle pulse on a key-up that occurs before `long_press`.
- long_press  output  1  one-cycle pulse when the hold time reaches T_LONG.
- repeat  output  1  one-cycle pulse every T_REPEAT cycles after `long_press` while the key is held.
- held  output  1  level; 1 from `press` until `release`, inclusive of the `press` cycle and exclusive of the `release` cycle.
- rpt_cnt  output  RW  number of `repeat` pulses since the last `press`; saturates at all-ones.

## Operation
- act = din XOR ACTIVE_LOW, so act = 1 means the key is pressed.
- State machine: S_IDLE, S_PRESS, S_LONG. The hold counter `cnt` is CNT_W bits wide.
- S_IDLE:
  - act=1: go to S_PRESS; press←1; cnt←0; rpt_cnt←0.
  - Otherwise stay in S_IDLE.
- S_PRESS:
  - act=0: go to S_IDLE; release←1; tap←1.
  - Else if cnt == T_LONG−1: go to S_LONG; long_press←1; cnt←0.
  - Else: cnt←cnt+1.
- S_LONG:
  - act=0: go to S_IDLE; release←1; tap stays 0.
  - Else if cnt == T_REPEAT−1: repeat←1; cnt←0; rpt_cnt←rpt_cnt+1, unless rpt_cnt is all-ones.
  - Else: cnt←cnt+1.
- Illegal state encoding: go to S_IDLE and clear `cnt`. No pulse is generated.
- `held` = (state ≠ S_IDLE).
- All pulse outputs are registered and are 0 in every cycle in which they are not explicitly set.
- Simultaneous events:
  - Key-up always wins.
  - Release on the same edge as the T_LONG threshold gives release + tap, and no long_press.
  - Release on the same edge as a repeat threshold gives release only; no repeat, and rpt_cnt is unchanged.
- `rpt_cnt` holds its value after release until the next `press` clears it.
- At most one of press, long_press, repeat and release is asserted in any cycle. `tap` is asserted only together with `release`.

## Timing
- Reset state, asynchronous and immediate:
  - state = S_IDLE, cnt = 0.
  - press = release = tap = long_press = repeat = 0.
  - held = 0, rpt_cnt = 0.
- Latency from `din` to events is 1 cycle. The pulse is high in the cycle following the first clock edge that samples the new level.
- `press` is high after edge E0. Then:
  - `long_press` is high after edge E0+T_LONG.
  - `repeat` is high after edges E0+T_LONG+k·T_REPEAT, for k ≥ 1.
- Minimum press-to-release spacing is 1 cycle. A key-up sampled at E0+1 gives `release` and `tap` after E0+1.
- Reset asserted mid-press returns all outputs to reset values. If the key is still active when n_rst deasserts, `press` fires after the first edge.
- No back-pressure: pulses are never held or queued.

## Test plan
All scenarios use T_LONG=8, T_REPEAT=4, RW=8, ACTIVE_LOW=1.
- Reset with din=1, then idle for 10 cycles → all outputs 0, rpt_cnt=0, held=0 throughout.
- din low sampled at E0..E4, high at E5 → press after E0; held high for cycles after E0..E4; release and tap after E5; no long_press.
- din low sampled at E0..E7, high at E8 (release on the threshold edge) → release and tap after E8; long_press never asserted.
- din low sampled at E0..E19, high at E20 → press after E0, long_press after E8, repeat after E12 and E16. At E20 there is release without tap and without repeat; rpt_cnt=2 and stays 2 after release.
- With RW=2, din held low for 35 cycles → repeats after E12, E16, E20, E24, E28, E32; rpt_cnt reads 1, 2, 3, 3, 3, 3; the next press clears it to 0.
- n_rst pulsed low at E10 of a long press while din stays low → outputs 0 immediately. After n_rst deasserts, press fires after the first edge and long_press fires 8 cycles later.
